// File: rtl/comp_seq_pkg.sv
// Shared types and constants for the sequential comparator controller.
//   SLICE_W : width of one comparator slice (the shared comparator is 2-bit)
//   state_t : controller states IDLE / CMP / DONE
package comp_seq_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_seq_cmp2.sv
// Existing 2-bit unsigned magnitude comparator, built from NAND terms.
// Purely combinational; used as the shared slice comparator.
// Ports:
//   a, b     : 2-bit operands
//   l, e, g  : a<b, a==b, a>b (exactly one is high)
module comp_seq_cmp2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       l,
    output logic       e,
    output logic       g
);

    logic na1, na0, nb1, nb0;
    logic n_g1, n_l1, n_g0, n_l0;
    logic e1, e0;

    assign na1  = ~(a[1] & a[1]);
    assign na0  = ~(a[0] & a[0]);
    assign nb1  = ~(b[1] & b[1]);
    assign nb0  = ~(b[0] & b[0]);

    // Per-bit greater/less terms, active low.
    assign n_g1 = ~(a[1] & nb1);
    assign n_l1 = ~(na1 & b[1]);
    assign n_g0 = ~(a[0] & nb0);
    assign n_l0 = ~(na0 & b[0]);

    // A bit is equal when it is neither greater nor less.
    assign e1   = ~(~(n_g1 & n_l1));
    assign e0   = ~(~(n_g0 & n_l0));

    // MSB decides; LSB only matters when the MSBs match.
    assign g    = ~(n_g1 & ~(e1 & ~n_g0));
    assign l    = ~(n_l1 & ~(e1 & ~n_l0));
    assign e    = ~(~(e1 & e0));

endmodule

// File: rtl/comp_seq_top.sv
// Wrapper pairing the sequential controller with one shared 2-bit comparator.
// Build option COMP_SEQ_EARLY_EXIT_EN is passed through to comp_seq_ctrl.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start, a, b  : request and operands
//   busy, done   : status, done is a one-cycle pulse
//   lt, eq, gt   : registered word result
module comp_seq_top
    import comp_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [SLICE_W-1:0] slice_a, slice_b;
    logic               slice_l, slice_e, slice_g;

    comp_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .lt      (lt),
        .eq      (eq),
        .gt      (gt),
        .slice_a (slice_a),
        .slice_b (slice_b),
        .slice_l (slice_l),
        .slice_e (slice_e),
        .slice_g (slice_g)
    );

    comp_seq_cmp2 u_cmp (
        .a (slice_a),
        .b (slice_b),
        .l (slice_l),
        .e (slice_e),
        .g (slice_g)
    );

endmodule

// File: rtl/comp_seq_ctrl.sv
// Sequential word comparator controller. Walks the captured operands one
// 2-bit slice per clock, MSB slice first, through an external comparator
// and produces registered lt/eq/gt flags for the whole word.
// Build option:
//   COMP_SEQ_EARLY_EXIT_EN defined : stop on the first unequal slice
//   undefined                      : always scan every slice, keep the first
//                                    unequal slice's verdict
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start                      : request, honoured only in IDLE
//   a, b                       : operands, captured on accepted start
//   busy                       : high in CMP and DONE
//   done                       : one-cycle pulse, flags valid
//   lt, eq, gt                 : registered word result
//   slice_a, slice_b           : current slice to the comparator (0 unless CMP)
//   slice_l, slice_e, slice_g  : comparator verdict for the current slice
//
//   state | meaning
//   IDLE  | waiting for start, flags hold last result
//   CMP   | presenting slice idx to the comparator
//   DONE  | flags loaded, done pulse
module comp_seq_ctrl
    import comp_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               lt,
    output logic               eq,
    output logic               gt,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    input  logic               slice_l,
    input  logic               slice_e,
    input  logic               slice_g
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    // slice_l is redundant with slice_e/slice_g for a trusted comparator.
    logic             slice_l_unused;
    assign slice_l_unused = slice_l;

`ifndef COMP_SEQ_EARLY_EXIT_EN
    // First unequal slice seen during the full scan, and its direction.
    logic hit_q, hit_d, hit_gt_q, hit_gt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
`ifndef COMP_SEQ_EARLY_EXIT_EN
            hit_q    <= 1'b0;
            hit_gt_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
`ifndef COMP_SEQ_EARLY_EXIT_EN
            hit_q    <= hit_d;
            hit_gt_q <= hit_gt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
`ifndef COMP_SEQ_EARLY_EXIT_EN
        hit_d    = hit_q;
        hit_gt_d = hit_gt_q;
`endif
        slice_a  = '0;
        slice_b  = '0;
        // idx*2 as shift amount selects the current 2-bit slice.
        a_sh     = a_q >> {idx_q, 1'b0};
        b_sh     = b_q >> {idx_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    state_d = CMP;
`ifndef COMP_SEQ_EARLY_EXIT_EN
                    hit_d   = 1'b0;
`endif
                end
            end
            CMP: begin
                slice_a = a_sh[SLICE_W-1:0];
                slice_b = b_sh[SLICE_W-1:0];
`ifdef COMP_SEQ_EARLY_EXIT_EN
                if (!slice_e) begin
                    gt_d    = slice_g;
                    lt_d    = ~slice_g;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
`else
                if (!hit_q && !slice_e) begin
                    hit_d    = 1'b1;
                    hit_gt_d = slice_g;
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                    // Flags change only on entry to DONE, so they stay
                    // stable for the whole scan.
                    if (hit_q) begin
                        gt_d = hit_gt_q;
                        lt_d = ~hit_gt_q;
                        eq_d = 1'b0;
                    end else if (!slice_e) begin
                        gt_d = slice_g;
                        lt_d = ~slice_g;
                        eq_d = 1'b0;
                    end else begin
                        gt_d = 1'b0;
                        lt_d = 1'b0;
                        eq_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
module tb_comp_seq_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, lt8, eq8, gt8;
    logic [1:0] sa8, sb8;
    logic       sl8, se8, sg8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, lt2, eq2, gt2;

    int checks = 0;
    int errors = 0;

    comp_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .lt      (lt8),
        .eq      (eq8),
        .gt      (gt8),
        .slice_a (sa8),
        .slice_b (sb8),
        .slice_l (sl8),
        .slice_e (se8),
        .slice_g (sg8)
    );

    comp_seq_cmp2 u_cmp8 (
        .a (sa8),
        .b (sb8),
        .l (sl8),
        .e (se8),
        .g (sg8)
    );

    comp_seq_top #(.WIDTH(2)) u_top2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .lt    (lt2),
        .eq    (eq2),
        .gt    (gt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;    // {lt, eq, gt}
        int         lat_ee;
        int         lat_full;
        string      nm;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: word flags by plain integer comparison.
    function automatic logic [2:0] model_flags(input int av, input int bv);
        return {av < bv, av == bv, av > bv};
    endfunction

    // Reference: start-to-done latency in cycles.
    function automatic int model_lat(input int w, input int av, input int bv);
        int nsl = w / 2;
        int k   = nsl;
        for (int i = nsl - 1; i >= 0; i--) begin
            if (((av >> (2 * i)) & 3) != ((bv >> (2 * i)) & 3)) begin
                k = nsl - i;
                break;
            end
        end
`ifdef COMP_SEQ_EARLY_EXIT_EN
        return k + 1;
`else
        return (k > 0) ? nsl + 1 : nsl + 1;
`endif
    endfunction

    function automatic logic sel_done(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction

    function automatic logic [2:0] sel_flags(input int w);
        return (w == 8) ? {lt8, eq8, gt8} : {lt2, eq2, gt2};
    endfunction

    // One full request: start, scramble operands after capture, wait for
    // done, check latency and flags, then check return to IDLE.
    task automatic run_cmp(input int w, input logic [7:0] av, input logic [7:0] bv,
                           input logic [2:0] exp_flags, input int exp_lat, input string nm);
        int cyc;
        if (w == 8) begin
            start8 = 1'b1; a8 = av; b8 = bv;
        end else begin
            start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0];
        end
        tick();
        start8 = 1'b0;
        start2 = 1'b0;
        a8 = ~av;
        b8 = 8'($urandom);
        a2 = ~av[1:0];
        b2 = 2'($urandom);
        if (w == 8) begin
            chk({nm, "_slice_a"}, 32'(sa8), 32'(av[7:6]));
            chk({nm, "_slice_b"}, 32'(sb8), 32'(bv[7:6]));
        end
        cyc = 1;
        while (!sel_done(w) && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_flags"}, 32'(sel_flags(w)), 32'(exp_flags));
        chk({nm, "_busy_in_done"}, 32'(sel_busy(w)), 32'd1);
        tick();
        chk({nm, "_idle_after"}, 32'({sel_done(w), sel_busy(w)}), 32'd0);
        if (w == 8) chk({nm, "_idle_slices"}, 32'({sa8, sb8}), 32'd0);
    endtask

    initial begin
        int nd;
        int dcyc;
        int lat;
        int cyc;
        logic [7:0] ra, rb;

        tbl[0] = '{8'hA5, 8'hA5, 3'b010, 5, 5, "eq_a5"};
        tbl[1] = '{8'h80, 8'h7F, 3'b001, 2, 5, "gt_msb"};
        tbl[2] = '{8'h12, 8'h13, 3'b100, 5, 5, "lt_lsb"};
        tbl[3] = '{8'h00, 8'hFF, 3'b100, 2, 5, "lt_msb"};
        tbl[4] = '{8'h03, 8'h01, 3'b001, 5, 5, "gt_lsb"};
        tbl[5] = '{8'h40, 8'h00, 3'b001, 2, 5, "gt_top"};
        tbl[6] = '{8'h0C, 8'h08, 3'b001, 4, 5, "gt_mid"};

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        #12;
        chk("reset_out8", 32'({busy8, done8, lt8, eq8, gt8, sa8, sb8}), 32'd0);
        chk("reset_out2", 32'({busy2, done2, lt2, eq2, gt2}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors.
        foreach (tbl[i]) begin
`ifdef COMP_SEQ_EARLY_EXIT_EN
            run_cmp(8, tbl[i].a, tbl[i].b, tbl[i].flags, tbl[i].lat_ee, tbl[i].nm);
`else
            run_cmp(8, tbl[i].a, tbl[i].b, tbl[i].flags, tbl[i].lat_full, tbl[i].nm);
`endif
        end

        // Flags hold through idle cycles.
        run_cmp(8, 8'h12, 8'h13, 3'b100, 5, "hold_run");
        for (int i = 0; i < 10; i++) begin
            chk("hold_flags", 32'({lt8, eq8, gt8}), 32'b100);
            tick();
        end

        // start held high while busy is ignored; accepted again once IDLE.
        lat = model_lat(8, 8'h00, 8'hFF);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
        tick();
        a8 = 8'hFF; b8 = 8'h00;
        nd = 0;
        dcyc = 0;
        for (int c = 1; c <= lat; c++) begin
            if (done8) begin
                nd++;
                dcyc = c;
                chk("busy_start_flags", 32'({lt8, eq8, gt8}), 32'b100);
            end
            tick();
        end
        chk("busy_start_ndone", 32'(nd), 32'd1);
        chk("busy_start_dcyc", 32'(dcyc), 32'(lat));
        chk("busy_start_idle", 32'(busy8), 32'd0);
        tick();
        chk("restart_accepted", 32'(busy8), 32'd1);
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("restart_latency", 32'(cyc), 32'(model_lat(8, 8'hFF, 8'h00)));
        chk("restart_flags", 32'({lt8, eq8, gt8}), 32'b001);
        tick();

        // Asynchronous reset mid-compare.
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h56;
        tick();
        start8 = 1'b0;
        tick();
        chk("pre_reset_busy", 32'(busy8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out8", 32'({busy8, done8, lt8, eq8, gt8, sa8, sb8}), 32'd0);
        chk("async_reset_out2", 32'({busy2, done2, lt2, eq2, gt2}), 32'd0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done8 || busy8) nd++;
        end
        chk("reset_no_done", 32'(nd), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_cmp(8, 8'h03, 8'h01, 3'b001, model_lat(8, 8'h03, 8'h01), "post_reset");

        // Random sweep, WIDTH=8.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom_range(0, 255));
            endcase
            run_cmp(8, ra, rb, model_flags(int'(ra), int'(rb)),
                    model_lat(8, int'(ra), int'(rb)), "rand8");
        end

        // Random sweep, WIDTH=2 through the wrapper.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 3));
            rb = 8'($urandom_range(0, 3));
            run_cmp(2, ra, rb, model_flags(int'(ra), int'(rb)),
                    model_lat(2, int'(ra), int'(rb)), "rand2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
